// File: rtl/serial_fsm_scheduler.sv
// Round-robin scheduler that time-shares one external serial sequence detector
// among four requesters, returning the p-high sample count for each served word.
module serial_fsm_scheduler #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   data,
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic                 done,
  output logic [CW-1:0]        hit_count,
  output logic                 final_hit,
  output logic                 eng_clear,
  output logic                 eng_en,
  output logic                 eng_w,
  input  logic                 eng_p
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       idx_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    acc_q;
  logic [CW-1:0]    bitcnt_q;
  logic [3:0]       gnt_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    hit_count_q;
  logic             final_hit_q;
  logic             eng_clear_q;
  logic             eng_en_q;
  logic             eng_w_q;

  logic [WIDTH-1:0] words [4];
  logic             pick_vld_d;
  logic [1:0]       pick_idx_d;
  logic [1:0]       cand;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      words[i] = data[i*WIDTH +: WIDTH];
    end
  end

  // First requesting index strictly after the last-granted one, wrapping.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pick_vld_d && req[cand]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = cand;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd3;
      idx_q       <= '0;
      shreg_q     <= '0;
      acc_q       <= '0;
      bitcnt_q    <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_count_q <= '0;
      final_hit_q <= 1'b0;
      eng_clear_q <= 1'b0;
      eng_en_q    <= 1'b0;
      eng_w_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            idx_q       <= pick_idx_d;
            shreg_q     <= words[pick_idx_d];
            gnt_q       <= 4'b0001 << pick_idx_d;
            busy_q      <= 1'b1;
            eng_clear_q <= 1'b1;
            state_q     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // Outputs are registered, so the first bit is presented on entry to SHIFT.
          eng_clear_q <= 1'b0;
          eng_en_q    <= 1'b1;
          eng_w_q     <= shreg_q[WIDTH-1];
          shreg_q     <= {shreg_q[WIDTH-2:0], 1'b0};
          acc_q       <= '0;
          bitcnt_q    <= '0;
          state_q     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (bitcnt_q != '0) begin
            acc_q <= acc_q + CW'(eng_p);
          end
          if (bitcnt_q == CW'(WIDTH - 1)) begin
            eng_en_q <= 1'b0;
            eng_w_q  <= 1'b0;
            state_q  <= S_SAMPLE;
          end else begin
            bitcnt_q <= bitcnt_q + 1'b1;
            eng_w_q  <= shreg_q[WIDTH-1];
            shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
          end
        end
        S_SAMPLE: begin
          hit_count_q <= acc_q + CW'(eng_p);
          final_hit_q <= eng_p;
          done_q      <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          ptr_q   <= idx_q;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          gnt_q       <= '0;
          busy_q      <= 1'b0;
          hit_count_q <= '0;
          final_hit_q <= 1'b0;
          eng_clear_q <= 1'b0;
          eng_en_q    <= 1'b0;
          eng_w_q     <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit_count = hit_count_q;
  assign final_hit = final_hit_q;
  assign eng_clear = eng_clear_q;
  assign eng_en    = eng_en_q;
  assign eng_w     = eng_w_q;

endmodule
